blink_ctrl: RTL and testbench

BLINK_CTRL -- requirements
Module: blink_ctrl

---
 rtl/blink_ctrl_pkg.sv | 13 +
 rtl/blink_ctrl_shadow.sv | 81 ++++++++
 rtl/blink_ctrl.sv | 151 +++++++++++++++
 tb/tb_blink_ctrl.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/blink_ctrl_pkg.sv
// Shared types and default widths for the blink_ctrl LED burst controller.
package blink_ctrl_pkg;

  localparam int unsigned CNT_W_DEF  = 40;
  localparam int unsigned PCNT_W_DEF = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

endpackage

// File: rtl/blink_ctrl_shadow.sv
// Config handshake: shadow register plus pending flag, promoted to the active
// config only when the FSM signals a period start.
module blink_ctrl_shadow
  import blink_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W  = CNT_W_DEF,
  parameter int unsigned PCNT_W = PCNT_W_DEF
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_cfg_valid,
  output logic              o_cfg_ready,
  input  logic [CNT_W-1:0]  i_cfg_period,
  input  logic [CNT_W-1:0]  i_cfg_on,
  input  logic [PCNT_W-1:0] i_cfg_count,
  input  logic [CNT_W-1:0]  i_cfg_gap,
  input  logic              i_apply,
  output logic              o_pending,
  output logic              o_act_valid,
  output logic [CNT_W-1:0]  o_act_period,
  output logic [CNT_W-1:0]  o_act_on,
  output logic [PCNT_W-1:0] o_act_count,
  output logic [CNT_W-1:0]  o_act_gap,
  output logic [CNT_W-1:0]  o_shd_period,
  output logic [CNT_W-1:0]  o_shd_on
);

  logic              r_pending;
  logic              r_act_valid;
  logic [CNT_W-1:0]  r_shd_period, r_shd_on, r_shd_gap;
  logic [PCNT_W-1:0] r_shd_count;
  logic [CNT_W-1:0]  r_act_period, r_act_on, r_act_gap;
  logic [PCNT_W-1:0] r_act_count;
  logic              w_accept;

  assign w_accept = i_cfg_valid & ~r_pending;

  // Accept needs !pending and apply needs pending, so a word accepted on a
  // period-start edge always waits for the following start.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_pending    <= 1'b0;
      r_act_valid  <= 1'b0;
      r_shd_period <= '0;
      r_shd_on     <= '0;
      r_shd_count  <= '0;
      r_shd_gap    <= '0;
      r_act_period <= '0;
      r_act_on     <= '0;
      r_act_count  <= '0;
      r_act_gap    <= '0;
    end else begin
      if (i_apply && r_pending) begin
        r_act_period <= r_shd_period;
        r_act_on     <= r_shd_on;
        r_act_count  <= r_shd_count;
        r_act_gap    <= r_shd_gap;
        r_act_valid  <= 1'b1;
        r_pending    <= 1'b0;
      end
      if (w_accept) begin
        r_shd_period <= i_cfg_period;
        r_shd_on     <= i_cfg_on;
        r_shd_count  <= i_cfg_count;
        r_shd_gap    <= i_cfg_gap;
        r_pending    <= 1'b1;
      end
    end
  end

  assign o_cfg_ready  = ~r_pending;
  assign o_pending    = r_pending;
  assign o_act_valid  = r_act_valid;
  assign o_act_period = r_act_period;
  assign o_act_on     = r_act_on;
  assign o_act_count  = r_act_count;
  assign o_act_gap    = r_act_gap;
  assign o_shd_period = r_shd_period;
  assign o_shd_on     = r_shd_on;

endmodule

// File: rtl/blink_ctrl.sv
// LED blink/burst controller: IDLE/RUN/GAP FSM with period, gap and pulse
// counters; config is double-buffered in blink_ctrl_shadow.
module blink_ctrl
  import blink_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W  = CNT_W_DEF,
  parameter int unsigned PCNT_W = PCNT_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [CNT_W-1:0]  cfg_period,
  input  logic [CNT_W-1:0]  cfg_on,
  input  logic [PCNT_W-1:0] cfg_count,
  input  logic [CNT_W-1:0]  cfg_gap,
  output logic              led,
  output logic              busy,
  output logic              burst_done
);

  state_t            r_state, w_state_nxt;
  logic [CNT_W-1:0]  r_tcnt, w_tcnt_nxt;
  logic [CNT_W-1:0]  r_gcnt, w_gcnt_nxt;
  logic [PCNT_W-1:0] r_pcnt, w_pcnt_nxt;
  logic              r_led, w_led_nxt;
  logic              w_start, w_done;

  logic              w_pending, w_act_valid;
  logic [CNT_W-1:0]  w_act_period, w_act_on, w_act_gap;
  logic [PCNT_W-1:0] w_act_count;
  logic [CNT_W-1:0]  w_shd_period, w_shd_on;

  logic [CNT_W-1:0]  w_per_eff, w_per_last;
  logic [CNT_W-1:0]  w_nx_period, w_nx_on, w_nx_per_eff, w_nx_on_eff;

  blink_ctrl_shadow #(
    .CNT_W  (CNT_W),
    .PCNT_W (PCNT_W)
  ) u_shadow (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_cfg_valid  (cfg_valid),
    .o_cfg_ready  (cfg_ready),
    .i_cfg_period (cfg_period),
    .i_cfg_on     (cfg_on),
    .i_cfg_count  (cfg_count),
    .i_cfg_gap    (cfg_gap),
    .i_apply      (w_start),
    .o_pending    (w_pending),
    .o_act_valid  (w_act_valid),
    .o_act_period (w_act_period),
    .o_act_on     (w_act_on),
    .o_act_count  (w_act_count),
    .o_act_gap    (w_act_gap),
    .o_shd_period (w_shd_period),
    .o_shd_on     (w_shd_on)
  );

  assign w_per_eff  = (w_act_period < CNT_W'(2)) ? CNT_W'(2) : w_act_period;
  assign w_per_last = w_per_eff - CNT_W'(1);

  // LED is registered from next-cycle tcnt, so a period start must see the
  // config that the shadow is about to promote.
  assign w_nx_period  = (w_start && w_pending) ? w_shd_period : w_act_period;
  assign w_nx_on      = (w_start && w_pending) ? w_shd_on     : w_act_on;
  assign w_nx_per_eff = (w_nx_period < CNT_W'(2)) ? CNT_W'(2) : w_nx_period;
  assign w_nx_on_eff  = (w_nx_on < w_nx_per_eff) ? w_nx_on : w_nx_per_eff;

  always_comb begin
    w_state_nxt = r_state;
    w_tcnt_nxt  = r_tcnt;
    w_gcnt_nxt  = r_gcnt;
    w_pcnt_nxt  = r_pcnt;
    w_start     = 1'b0;
    w_done      = 1'b0;
    if (!enable) begin
      w_state_nxt = ST_IDLE;
      w_tcnt_nxt  = '0;
      w_gcnt_nxt  = '0;
      w_pcnt_nxt  = '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_act_valid || w_pending) begin
            w_state_nxt = ST_RUN;
            w_tcnt_nxt  = '0;
            w_pcnt_nxt  = '0;
            w_start     = 1'b1;
          end
        end
        ST_RUN: begin
          if (r_tcnt == w_per_last) begin
            w_tcnt_nxt = '0;
            if (w_act_count == '0) begin
              w_start = 1'b1;
            end else if (r_pcnt == w_act_count - PCNT_W'(1)) begin
              w_done     = 1'b1;
              w_pcnt_nxt = '0;
              if (w_act_gap != '0) begin
                w_state_nxt = ST_GAP;
                w_gcnt_nxt  = '0;
              end else begin
                w_start = 1'b1;
              end
            end else begin
              w_pcnt_nxt = r_pcnt + PCNT_W'(1);
              w_start    = 1'b1;
            end
          end else begin
            w_tcnt_nxt = r_tcnt + CNT_W'(1);
          end
        end
        ST_GAP: begin
          if (r_gcnt == w_act_gap - CNT_W'(1)) begin
            w_state_nxt = ST_RUN;
            w_tcnt_nxt  = '0;
            w_gcnt_nxt  = '0;
            w_start     = 1'b1;
          end else begin
            w_gcnt_nxt = r_gcnt + CNT_W'(1);
          end
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end
    w_led_nxt = (w_state_nxt == ST_RUN) && (w_tcnt_nxt < w_nx_on_eff);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
      r_tcnt  <= '0;
      r_gcnt  <= '0;
      r_pcnt  <= '0;
      r_led   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_tcnt  <= w_tcnt_nxt;
      r_gcnt  <= w_gcnt_nxt;
      r_pcnt  <= w_pcnt_nxt;
      r_led   <= w_led_nxt;
    end
  end

  assign led        = r_led;
  assign busy       = (r_state != ST_IDLE);
  assign burst_done = w_done;

endmodule

// File: tb/tb_blink_ctrl.sv
// Directed and random stimulus for blink_ctrl, checked against a queue-based
// model that expands each period/gap into its expected per-cycle outputs.
module tb_blink_ctrl;

  localparam int unsigned CW = 40;
  localparam int unsigned PW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          enable = 1'b0;
  logic          cfg_valid = 1'b0;
  logic          cfg_ready;
  logic [CW-1:0] cfg_period = '0;
  logic [CW-1:0] cfg_on = '0;
  logic [PW-1:0] cfg_count = '0;
  logic [CW-1:0] cfg_gap = '0;
  logic          led, busy, burst_done;

  always #5 clk = ~clk;

  blink_ctrl #(.CNT_W(CW), .PCNT_W(PW)) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .cfg_valid  (cfg_valid),
    .cfg_ready  (cfg_ready),
    .cfg_period (cfg_period),
    .cfg_on     (cfg_on),
    .cfg_count  (cfg_count),
    .cfg_gap    (cfg_gap),
    .led        (led),
    .busy       (busy),
    .burst_done (burst_done)
  );

  typedef struct packed { logic led; logic done; } exp_t;

  exp_t q[$];
  int   a_per, a_on, a_cnt, a_gap, s_per, s_on, s_cnt, s_gap, m_p;
  bit   a_valid, pend, running;
  int unsigned n_checks = 0, n_pass = 0, n_fail = 0;
  logic obs_led, obs_done, obs_busy, obs_ready;
  logic [8:0] pat34;

  task automatic chk(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic m_reset();
    q.delete();
    running = 0; pend = 0; a_valid = 0; m_p = 0;
  endtask

  task automatic m_start();
    int pe, oe;
    bit last;
    exp_t e;
    if (pend) begin
      a_per = s_per; a_on = s_on; a_cnt = s_cnt; a_gap = s_gap;
      pend = 0; a_valid = 1;
    end
    pe = (a_per < 2) ? 2 : a_per;
    oe = (a_on < pe) ? a_on : pe;
    last = (a_cnt != 0) && (m_p == a_cnt - 1);
    if (last) m_p = 0;
    else if (a_cnt != 0) m_p = (m_p + 1) % 256;
    running = 1;
    for (int i = 0; i < pe; i++) begin
      e.led  = (i < oe);
      e.done = last && (i == pe - 1);
      q.push_back(e);
    end
    if (last) begin
      for (int i = 0; i < a_gap; i++) begin
        e = '0;
        q.push_back(e);
      end
    end
  endtask

  task automatic m_step(input bit en, input bit acc, input int per, on, cnt, gap);
    if (!en) begin
      q.delete();
      running = 0;
    end else if (!running) begin
      if (a_valid || pend) begin
        m_p = 0;
        m_start();
      end
    end else begin
      void'(q.pop_front());
      if (q.size() == 0) m_start();
    end
    if (acc) begin
      s_per = per; s_on = on; s_cnt = cnt; s_gap = gap; pend = 1;
    end
  endtask

  // One clock cycle: drive inputs after the falling edge, check, then advance the model.
  task automatic cyc(input bit en, input bit v, input int per, on, cnt, gap);
    bit acc;
    enable = en; cfg_valid = v;
    cfg_period = CW'(per); cfg_on = CW'(on); cfg_count = PW'(cnt); cfg_gap = CW'(gap);
    #1;
    chk("led",        led,        running ? q[0].led : 1'b0);
    chk("busy",       busy,       running);
    chk("burst_done", burst_done, running && en && q[0].done);
    chk("cfg_ready",  cfg_ready,  !pend);
    obs_led = led; obs_done = burst_done; obs_busy = busy; obs_ready = cfg_ready;
    acc = v && !pend;
    @(posedge clk);
    m_step(en, acc, per, on, cnt, gap);
    @(negedge clk);
  endtask

  task automatic do_reset();
    #2 rst = 1'b0;
    #1;
    chk("rst_led",   led,        1'b0);
    chk("rst_busy",  busy,       1'b0);
    chk("rst_done",  burst_done, 1'b0);
    chk("rst_ready", cfg_ready,  1'b1);
    m_reset();
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) cyc(1, 0, 0, 0, 0, 0);
  endtask

  initial begin
    m_reset();
    #3;
    chk("init_led",   led,        1'b0);
    chk("init_busy",  busy,       1'b0);
    chk("init_done",  burst_done, 1'b0);
    chk("init_ready", cfg_ready,  1'b1);
    @(negedge clk);
    rst = 1'b1;

    // Continuous 1-of-4 pattern.
    cyc(1, 1, 4, 1, 0, 0);
    cyc(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 12; i++) begin
      cyc(1, 0, 0, 0, 0, 0);
      chk("p33_led",  obs_led,  (i % 4) == 0);
      chk("p33_done", obs_done, 1'b0);
    end

    // Two-pulse bursts with a three-tick gap.
    do_reset();
    pat34 = 9'b110110000;
    cyc(1, 1, 3, 2, 2, 3);
    cyc(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 18; i++) begin
      cyc(1, 0, 0, 0, 0, 0);
      chk("p34_led",  obs_led,  pat34[8 - (i % 9)]);
      chk("p34_done", obs_done, (i % 9) == 5);
    end

    // on > period saturates high; on = 0 stays low while busy.
    do_reset();
    cyc(1, 1, 3, 5, 0, 0);
    idle_cycles(3);
    for (int i = 0; i < 4; i++) begin
      cyc(1, 0, 0, 0, 0, 0);
      chk("p35_on_hi", obs_led, 1'b1);
    end
    cyc(1, 1, 3, 0, 0, 0);
    idle_cycles(4);
    for (int i = 0; i < 4; i++) begin
      cyc(1, 0, 0, 0, 0, 0);
      chk("p35_on0_led",  obs_led,  1'b0);
      chk("p35_on0_busy", obs_busy, 1'b1);
    end

    // Mid-period reconfiguration lands exactly at the wrap.
    do_reset();
    cyc(1, 1, 4, 1, 0, 0);
    idle_cycles(3);
    cyc(1, 1, 2, 1, 0, 0);
    cyc(1, 0, 0, 0, 0, 0);
    chk("p36_ready_low", obs_ready, 1'b0);
    chk("p36_last_old",  obs_led,   1'b0);
    cyc(1, 0, 0, 0, 0, 0);
    chk("p36_ready_hi", obs_ready, 1'b1);
    chk("p36_new0",     obs_led,   1'b1);
    cyc(1, 0, 0, 0, 0, 0);
    chk("p36_new1", obs_led, 1'b0);
    cyc(1, 0, 0, 0, 0, 0);
    chk("p36_new2", obs_led, 1'b1);

    // Enable dropped mid-gap, then restored with the retained config.
    do_reset();
    cyc(1, 1, 3, 2, 2, 3);
    idle_cycles(8);
    cyc(0, 0, 0, 0, 0, 0);
    chk("p37_gap_led", obs_led, 1'b0);
    cyc(1, 0, 0, 0, 0, 0);
    chk("p37_idle", obs_busy, 1'b0);
    cyc(1, 0, 0, 0, 0, 0);
    chk("p37_restart", obs_led, 1'b1);
    idle_cycles(10);

    // Reset mid-run discards the config; nothing runs until a new one arrives.
    do_reset();
    idle_cycles(5);
    chk("p38_no_run", obs_busy, 1'b0);
    cyc(1, 1, 2, 1, 1, 0);
    idle_cycles(8);

    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 299) == 0) do_reset();
      cyc($urandom_range(0, 15) != 0, $urandom_range(0, 3) == 0,
          int'($urandom_range(0, 6)), int'($urandom_range(0, 7)),
          int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
